// File: rtl/vga_tile_pkg.sv
// Shared encodings, bar palette and sprite artwork for the snake tile renderer.
package vga_tile_pkg;

  typedef enum logic [1:0] {
    MODE_GAME    = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ENT_NOTHING = 2'd0,
    ENT_HEAD    = 2'd1,
    ENT_BODY    = 2'd2,
    ENT_FOOD    = 2'd3
  } ent_e;

  localparam int SPRITE_N   = 3;
  localparam int SPRITE_DIM = 16;

  // Per-sprite colour {R,G,B}; the shape rows below gate it on or off.
  localparam logic [2:0] SPRITE_COLOR [SPRITE_N] = '{3'b010, 3'b110, 3'b100};

  // Row y, bit (15 - x): 1 = sprite colour, 0 = black.
  localparam logic [15:0] SPRITE_ROWS [SPRITE_N][SPRITE_DIM] = '{
    '{0: 16'h0000, 15: 16'h0000, default: 16'h7FFE},
    '{0: 16'h0000, 15: 16'h0000, default: 16'hFFFF},
    '{6: 16'h03C0, 7: 16'h03C0, 8: 16'h03C0, 9: 16'h03C0, default: 16'h0000}
  };

  function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
    return {~bar[2], ~bar[0], ~bar[1]};
  endfunction

  function automatic logic [2:0] sprite_rgb(input logic [7:0] s, input logic [3:0] x,
                                            input logic [3:0] y);
    logic [15:0] row;
    row = 16'h0000;
    if (s >= 8'(SPRITE_N)) return 3'b000;
    row = SPRITE_ROWS[s[1:0]][y];
    return row[4'd15 - x] ? SPRITE_COLOR[s[1:0]] : 3'b000;
  endfunction

endpackage

// File: rtl/vga_tile_renderer_rom.sv
// Synchronous sprite ROM: one word per (sprite, local x, local y), 1-cycle read latency.
import vga_tile_pkg::*;

module vga_sprite_rom #(
  parameter int COLOR_W = 1,
  parameter int TILE_W  = 16,
  parameter int TILE_H  = 16,
  parameter int ENT_N   = 4
) (
  input  logic                         clk,
  input  logic [$clog2(ENT_N)-1:0]     sprite,
  input  logic [$clog2(TILE_W)-1:0]    x,
  input  logic [$clog2(TILE_H)-1:0]    y,
  output logic [3*COLOR_W-1:0]         data
);

  logic [2:0] px;

  // Artwork is 16x16; other tile sizes wrap or crop it through the 4-bit casts.
  assign px = sprite_rgb(8'(sprite), 4'(x), 4'(y));

  always_ff @(posedge clk) begin
    data <= {{COLOR_W{px[2]}}, {COLOR_W{px[1]}}, {COLOR_W{px[0]}}};
  end

endmodule

// File: rtl/vga_tile_renderer.sv
// Snake display pixel generator: game sprites, colour bars or checkerboard, 2-cycle latency.
// Optional blinking of one entity is compiled in with VGA_TILE_BLINK_EN.
import vga_tile_pkg::*;

module vga_tile_renderer #(
  parameter int COLOR_W     = 1,
  parameter int TILE_W      = 16,
  parameter int TILE_H      = 16,
  parameter int ENT_N       = 4,
  parameter int BAR_H       = 60,
  parameter int BLINK_ENT   = 1,
  parameter int BLINK_SHIFT = 4
) (
  input  logic                     iVGA_CLK,
  input  logic                     reset,
  input  logic [9:0]               iVGA_X,
  input  logic [9:0]               iVGA_Y,
  input  logic                     iValid,
  input  logic [1:0]               iMode,
  input  logic [$clog2(ENT_N)-1:0] iEnt,
  output logic [COLOR_W-1:0]       oRed,
  output logic [COLOR_W-1:0]       oGreen,
  output logic [COLOR_W-1:0]       oBlue,
  output logic                     oValid
);

  localparam int ENT_W  = $clog2(ENT_N);
  localparam int LX_W   = $clog2(TILE_W);
  localparam int LY_W   = $clog2(TILE_H);
  localparam int LINE_W = $clog2(BAR_H + 1);
  localparam int CW     = 3 * COLOR_W;

  function automatic logic [CW-1:0] expand(input logic [2:0] c);
    return {{COLOR_W{c[2]}}, {COLOR_W{c[1]}}, {COLOR_W{c[0]}}};
  endfunction

  logic              frame_start, line_start;
  logic [1:0]        mode_q, mode_cur;
  logic [LINE_W-1:0] line_q, line_nxt;
  logic [2:0]        bar_q, bar_nxt;
  logic              ent_ok, blank;

  logic              vld_p1;
  logic [1:0]        mode_p1;
  logic              parity_p1, ent_ok_p1;
  logic [2:0]        bar_rgb_p1;
  logic [CW-1:0]     rom_p1;
  logic [CW-1:0]     rgb_sel;
  logic [CW-1:0]     rgb_p2;

  assign frame_start = iValid && (iVGA_X == 10'd0) && (iVGA_Y == 10'd0);
  assign line_start  = iValid && (iVGA_X == 10'd0);
  assign mode_cur    = frame_start ? iMode : mode_q;

  always_comb begin
    line_nxt = line_q;
    bar_nxt  = bar_q;
    if (frame_start) begin
      line_nxt = '0;
      bar_nxt  = 3'd0;
    end else if (line_start) begin
      if (line_q == LINE_W'(BAR_H - 1)) begin
        line_nxt = '0;
        bar_nxt  = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
      end else begin
        line_nxt = line_q + LINE_W'(1);
      end
    end
  end

`ifdef VGA_TILE_BLINK_EN
  logic [BLINK_SHIFT:0] frame_q, frame_nxt;
  logic                 started_q;

  // The first frame after reset is frame 0, so its start does not count.
  always_comb begin
    frame_nxt = frame_q;
    if (frame_start && started_q) frame_nxt = frame_q + (BLINK_SHIFT + 1)'(1);
  end

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      frame_q   <= '0;
      started_q <= 1'b0;
    end else begin
      frame_q <= frame_nxt;
      if (frame_start) started_q <= 1'b1;
    end
  end

  assign blank = (32'(iEnt) == BLINK_ENT) && frame_nxt[BLINK_SHIFT];
`else
  assign blank = 1'b0;
`endif

  assign ent_ok = (iEnt != ENT_W'(ENT_NOTHING)) && (32'(iEnt) < ENT_N) && !blank;

  vga_sprite_rom #(
    .COLOR_W (COLOR_W),
    .TILE_W  (TILE_W),
    .TILE_H  (TILE_H),
    .ENT_N   (ENT_N)
  ) u_rom (
    .clk    (iVGA_CLK),
    .sprite (iEnt - ENT_W'(1)),
    .x      (iVGA_X[LX_W-1:0]),
    .y      (iVGA_Y[LY_W-1:0]),
    .data   (rom_p1)
  );

  // Stage 1: latch mode, counters and per-pixel attributes
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_GAME;
      line_q  <= '0;
      bar_q   <= 3'd0;
      vld_p1  <= 1'b0;
      mode_p1 <= MODE_GAME;
    end else begin
      mode_q  <= mode_cur;
      line_q  <= line_nxt;
      bar_q   <= bar_nxt;
      vld_p1  <= iValid;
      mode_p1 <= mode_cur;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    parity_p1  <= iVGA_X[LX_W] ^ iVGA_Y[LY_W];
    ent_ok_p1  <= ent_ok;
    bar_rgb_p1 <= bar_rgb(bar_nxt);
  end

  // Stage 2: mode mux on the registered ROM word, then output registers
  always_comb begin
    rgb_sel = '0;
    if (vld_p1) begin
      case (mode_p1)
        MODE_BARS:    rgb_sel = expand(bar_rgb_p1);
        MODE_CHECKER: rgb_sel = parity_p1 ? '0 : '1;
        default:      rgb_sel = ent_ok_p1 ? rom_p1 : '0;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      rgb_p2 <= '0;
      oValid <= 1'b0;
    end else begin
      rgb_p2 <= rgb_sel;
      oValid <= vld_p1;
    end
  end

  assign oRed   = rgb_p2[3*COLOR_W-1 -: COLOR_W];
  assign oGreen = rgb_p2[2*COLOR_W-1 -: COLOR_W];
  assign oBlue  = rgb_p2[COLOR_W-1 -: COLOR_W];

endmodule
